// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter and sequencer for one shared, fixed-latency,
// non-pipelined floating-point unit. It accepts one operand pair per grant,
// holds the pair on the unit for LATENCY cycles, then captures the unit result
// and returns it to the granted requester with a one-cycle response pulse.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   req_valid    per-requester request valid
//   req_a/req_b  packed operands, requester i at [i*PRECISION +: PRECISION]
//   req_ready    combinational one-hot (or zero) grant/accept
//   resp_valid   registered one-hot result pulse
//   resp_data    registered result, held until the next capture
//   unit_a/b     registered operands driven to the shared unit
//   unit_result  result returned by the shared unit
//   grant_id     index of the current/last granted requester
//   busy         high while an operation is in flight
module fp_unit_arbiter #(
    parameter int unsigned PRECISION = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned LATENCY   = 4,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*PRECISION-1:0] req_a,
    input  logic [NREQ*PRECISION-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [PRECISION-1:0]      resp_data,
    output logic [PRECISION-1:0]      unit_a,
    output logic [PRECISION-1:0]      unit_b,
    input  logic [PRECISION-1:0]      unit_result,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam logic [3:0] LatCnt = 4'(LATENCY);

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     cnt;

    logic           found;
    logic [IDW-1:0] gsel;
    logic [IDW-1:0] idx;
    logic           handshake;

    // Scan from rr_ptr upward; NREQ is a power of two so IDW-bit addition
    // wraps modulo NREQ for free.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + IDW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end
    end

    // Ready is suppressed during reset so a requester never sees an accept
    // that the registers will not honour.
    always_comb begin
        req_ready = '0;
        if (state == StIdle && found && !reset) begin
            req_ready[gsel] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign busy      = (state == StWait);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            rr_ptr     <= '0;
            cnt        <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            resp_data  <= '0;
            resp_valid <= '0;
            grant_id   <= '0;
        end else begin
            resp_valid <= '0;
            unique case (state)
                StIdle: begin
                    if (handshake) begin
                        unit_a   <= req_a[gsel*PRECISION +: PRECISION];
                        unit_b   <= req_b[gsel*PRECISION +: PRECISION];
                        grant_id <= gsel;
                        rr_ptr   <= gsel + 1'b1;
                        cnt      <= 4'd1;
                        state    <= StWait;
                    end
                end
                StWait: begin
                    // cnt equals the number of edges since the handshake, so
                    // the capture edge is the one where it reaches LATENCY.
                    if (cnt == LatCnt) begin
                        resp_data  <= unit_result;
                        resp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
                        cnt        <= '0;
                        state      <= StIdle;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
